// File: rtl/decoder_pulse.sv
// Registered binary-to-one-hot decoder: one accepted code drives its line for HOLD_CYCLES clocks, then all-zero.
// Latency: acceptance cycle N -> line high in cycles N+1..N+HOLD_CYCLES, zero in N+HOLD_CYCLES+1; range_err in N+1.
// Backpressure: in_ready low while a line is held, while enable is low, or during reset. DECODER_PULSE_STICKY_ERR_EN makes range_err sticky.
module decoder_pulse #(
    parameter int IN_WIDTH    = 4,
    parameter int OUT_WIDTH   = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [IN_WIDTH-1:0]  binary_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] decoder_out,
    output logic                 out_valid,
    output logic                 range_err
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [OUT_WIDTH-1:0] ONE_LSB  = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             in_range;

    // Reset gates in_ready so a request presented alongside reset is never seen as taken.
    assign in_ready = enable && (state == ST_IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign in_range = (32'(binary_in) < 32'(OUT_WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            decoder_out <= '0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && in_range) begin
                        decoder_out <= ONE_LSB << binary_in;
                        out_valid   <= 1'b1;
                        cnt         <= CNT_LOAD;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Dropping enable aborts the pulse; the remaining count is discarded.
                    if (!enable || (cnt == '0)) begin
                        decoder_out <= '0;
                        out_valid   <= 1'b0;
                        cnt         <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    decoder_out <= '0;
                    out_valid   <= 1'b0;
                    cnt         <= '0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DECODER_PULSE_STICKY_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            range_err <= 1'b0;
        end else if (accept && !in_range) begin
            range_err <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            range_err <= 1'b0;
        end else begin
            range_err <= accept && !in_range;
        end
    end
`endif

endmodule
